// File: rtl/key_repeat_pkg.sv
// Shared types and tuning constants for the key auto-repeat stage.
package key_repeat_pkg;

  // Per-channel repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Default timing, in game ticks (60 Hz).
  localparam int DAS_TICKS_DEF   = 16;
  localparam int ARR_TICKS_DEF   = 6;
  localparam int SDROP_TICKS_DEF = 2;

  // Channel indices into the packed key/command vectors.
  localparam int NUM_CH    = 5;
  localparam int CH_LEFT   = 0;
  localparam int CH_RIGHT  = 1;
  localparam int CH_DOWN   = 2;
  localparam int CH_ROTATE = 3;
  localparam int CH_DROP   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Tick counter width; the counter clears on match so it never wraps.
  function automatic int cnt_width(input int das, input int arr, input int sdrop);
    return $clog2(max3(das, arr, sdrop) + 1);
  endfunction

endpackage

// File: rtl/key_repeat_if.sv
// Key levels in, command pulses out, plus the game tick and enable.
interface key_repeat_if;
  logic tick_game;
  logic enable;
  logic key_left;
  logic key_right;
  logic key_down;
  logic key_rotate;
  logic key_drop;
  logic cmd_left;
  logic cmd_right;
  logic cmd_down;
  logic cmd_rotate;
  logic cmd_drop;

  // Producer of key levels / consumer of commands (keyboard + game side).
  modport master (
    output tick_game, enable,
    output key_left, key_right, key_down, key_rotate, key_drop,
    input  cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop
  );

  // The repeat stage itself.
  modport slave (
    input  tick_game, enable,
    input  key_left, key_right, key_down, key_rotate, key_drop,
    output cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop
  );
endinterface

// File: rtl/key_repeat_ch.sv
// One key channel: press-edge pulse, optional delayed auto-repeat.
module key_repeat_ch
  import key_repeat_pkg::*;
#(
  parameter int FIRST_TICKS  = DAS_TICKS_DEF,
  parameter int PERIOD_TICKS = ARR_TICKS_DEF,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int CNT_W        = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic key,
  input  logic force_idle,
  output logic cmd
);

  localparam logic [CNT_W-1:0] FIRST_LAST  = CNT_W'(FIRST_TICKS - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_TICKS - 1);

  rep_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             prev_q;
  logic             press;
  logic             pulse;

  // prev_q keeps tracking the key even while forced idle, so a key held
  // across a suppression window never produces a fresh press edge.
  assign press = key & ~prev_q;

  // State, counter, edge history and the registered command pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      prev_q    <= 1'b0;
      cmd       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      prev_q    <= key;
      cmd       <= pulse;
    end
  end

  // Next state: a press restarts timing (that cycle's tick is not counted).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!key || force_idle) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press) begin
            cnt_next   = '0;
            state_next = REPEAT_EN ? DELAY : IDLE;
          end
        end
        DELAY: begin
          if (tick_game) begin
            if (cnt_reg == FIRST_LAST) begin
              cnt_next   = '0;
              state_next = REPEAT;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (tick_game) begin
            if (cnt_reg == PERIOD_LAST) begin
              cnt_next = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Pulse decode: press in IDLE, counter match on a tick otherwise.
  always_comb begin
    pulse = 1'b0;
    if (key && !force_idle) begin
      case (state_reg)
        IDLE:    pulse = press;
        DELAY:   pulse = tick_game && (cnt_reg == FIRST_LAST);
        REPEAT:  pulse = tick_game && (cnt_reg == PERIOD_LAST);
        default: pulse = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/key_repeat.sv
// Converts held key levels into one-cycle game commands with DAS/ARR repeat.
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int DAS_TICKS   = DAS_TICKS_DEF,
  parameter int ARR_TICKS   = ARR_TICKS_DEF,
  parameter int SDROP_TICKS = SDROP_TICKS_DEF
) (
  input logic         clk,
  input logic         rst,
  key_repeat_if.slave kb
);

  localparam int CNT_W = cnt_width(DAS_TICKS, ARR_TICKS, SDROP_TICKS);

  logic [NUM_CH-1:0] key_vec;
  logic [NUM_CH-1:0] force_vec;
  logic [NUM_CH-1:0] cmd_vec;
  logic              hz_conflict;

  assign key_vec = {kb.key_drop, kb.key_rotate, kb.key_down, kb.key_right, kb.key_left};

  // Opposing horizontal keys cancel each other out entirely.
  assign hz_conflict = kb.key_left & kb.key_right;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam bit HORIZ  = (gi == CH_LEFT) || (gi == CH_RIGHT);
      localparam bit REP_EN = HORIZ || (gi == CH_DOWN);
      // Soft drop repeats evenly from the press; left/right use DAS then ARR.
      localparam int FIRST  = (gi == CH_DOWN) ? SDROP_TICKS : DAS_TICKS;
      localparam int PERIOD = (gi == CH_DOWN) ? SDROP_TICKS : ARR_TICKS;

      assign force_vec[gi] = ~kb.enable | (HORIZ ? hz_conflict : 1'b0);

      key_repeat_ch #(
        .FIRST_TICKS  (FIRST),
        .PERIOD_TICKS (PERIOD),
        .REPEAT_EN    (REP_EN),
        .CNT_W        (CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .tick_game  (kb.tick_game),
        .key        (key_vec[gi]),
        .force_idle (force_vec[gi]),
        .cmd        (cmd_vec[gi])
      );
    end
  endgenerate

  assign kb.cmd_left   = cmd_vec[CH_LEFT];
  assign kb.cmd_right  = cmd_vec[CH_RIGHT];
  assign kb.cmd_down   = cmd_vec[CH_DOWN];
  assign kb.cmd_rotate = cmd_vec[CH_ROTATE];
  assign kb.cmd_drop   = cmd_vec[CH_DROP];

endmodule

// File: tb/tb_key_repeat.sv
// Scoreboard bench for key_repeat: directed scenarios plus random stimulus.
module tb_key_repeat;
  import key_repeat_pkg::*;

  localparam int DAS = 16;
  localparam int ARR = 6;
  localparam int SD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_repeat_if kif ();

  key_repeat #(
    .DAS_TICKS   (DAS),
    .ARR_TICKS   (ARR),
    .SDROP_TICKS (SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kb  (kif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus state.
  logic [4:0] keys    = '0;
  logic       tick    = 1'b0;
  logic       en      = 1'b1;
  logic       rst_drv = 1'b1;

  // Reference model: per key, whether a press is being timed and how many
  // ticks have elapsed since that press.
  logic [4:0] m_prev = '0;
  bit         m_armed [5];
  int         m_t     [5];
  logic [4:0] last_exp = '0;
  logic [4:0] exp_q [$];
  int         pulse_cnt [5];
  int         cyc = 0;

  task automatic check(input string name, input int actual, input int req);
    n_checks++;
    if (actual == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, actual, req);
  endtask

  function automatic logic [4:0] dut_cmds();
    return {kif.cmd_drop, kif.cmd_rotate, kif.cmd_down, kif.cmd_right, kif.cmd_left};
  endfunction

  function automatic void model_step();
    logic [4:0] e;
    bit forced, edge_c;
    int first, period;
    e = '0;
    if (rst_drv) begin
      m_prev = '0;
      for (int c = 0; c < 5; c++) begin
        m_armed[c] = 0;
        m_t[c] = 0;
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        first  = (c == CH_DOWN) ? SD : DAS;
        period = (c == CH_DOWN) ? SD : ARR;
        edge_c = keys[c] && !m_prev[c];
        forced = !en || ((c == CH_LEFT || c == CH_RIGHT) && keys[CH_LEFT] && keys[CH_RIGHT]);
        if (!keys[c] || forced) begin
          m_armed[c] = 0;
          m_t[c] = 0;
        end else if (edge_c) begin
          m_armed[c] = 1;
          m_t[c] = 0;
          e[c] = 1'b1;
        end else if (m_armed[c] && tick && c <= CH_DOWN) begin
          m_t[c]++;
          if (m_t[c] == first || (m_t[c] > first && (m_t[c] - first) % period == 0))
            e[c] = 1'b1;
        end
      end
      m_prev = keys;
    end
    last_exp = e;
  endfunction

  // Apply one cycle of stimulus and queue the response it should produce.
  task automatic step();
    @(negedge clk);
    rst            = rst_drv;
    kif.tick_game  = tick;
    kif.enable     = en;
    kif.key_left   = keys[CH_LEFT];
    kif.key_right  = keys[CH_RIGHT];
    kif.key_down   = keys[CH_DOWN];
    kif.key_rotate = keys[CH_ROTATE];
    kif.key_drop   = keys[CH_DROP];
    model_step();
    exp_q.push_back(last_exp);
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Each tick occupies three clocks: one tick cycle, two quiet cycles.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
    end
  endtask

  // Monitor: compare every presented command vector against the scoreboard.
  initial begin
    logic [4:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_cmds();
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cmd_vec cycle %0d: got %b, required %b", cyc, a, e);
        for (int c = 0; c < 5; c++) if (a[c] === 1'b1) pulse_cnt[c]++;
      end
    end
  end

  initial begin
    int base;
    int seen;
    bit found;
    kif.tick_game = 1'b0;
    kif.enable = 1'b1;
    kif.key_left = 1'b0;
    kif.key_right = 1'b0;
    kif.key_down = 1'b0;
    kif.key_rotate = 1'b0;
    kif.key_drop = 1'b0;

    // Key held through reset release: press pulse, then DAS at 16, ARR at 22.
    keys[CH_LEFT] = 1'b1;
    idle(3);
    check("reset_cmds_zero", int'(dut_cmds()), 0);
    base = pulse_cnt[CH_LEFT];
    rst_drv = 1'b0;
    idle(1);
    run_ticks(22);
    keys = '0;
    idle(3);
    check("left_held_thru_reset", pulse_cnt[CH_LEFT] - base, 3);

    // Left held 40 ticks, released at tick 41.
    base = pulse_cnt[CH_LEFT];
    keys[CH_LEFT] = 1'b1;
    idle(1);
    run_ticks(40);
    keys = '0;
    run_ticks(1);
    idle(2);
    check("left_40_ticks", pulse_cnt[CH_LEFT] - base, 6);

    // Down held 7 ticks.
    base = pulse_cnt[CH_DOWN];
    keys[CH_DOWN] = 1'b1;
    idle(1);
    run_ticks(7);
    keys = '0;
    idle(3);
    check("down_7_ticks", pulse_cnt[CH_DOWN] - base, 4);

    // Rotate held 100 ticks, then re-pressed.
    base = pulse_cnt[CH_ROTATE];
    keys[CH_ROTATE] = 1'b1;
    idle(1);
    run_ticks(100);
    keys = '0;
    idle(3);
    check("rotate_hold", pulse_cnt[CH_ROTATE] - base, 1);
    base = pulse_cnt[CH_ROTATE];
    keys[CH_ROTATE] = 1'b1;
    run_ticks(3);
    keys = '0;
    idle(3);
    check("rotate_repress", pulse_cnt[CH_ROTATE] - base, 1);

    // Left held, right joins at tick 5, right leaves at tick 10.
    base = pulse_cnt[CH_LEFT];
    seen = pulse_cnt[CH_RIGHT];
    keys[CH_LEFT] = 1'b1;
    idle(1);
    run_ticks(5);
    keys[CH_RIGHT] = 1'b1;
    run_ticks(5);
    keys[CH_RIGHT] = 1'b0;
    run_ticks(25);
    keys = '0;
    idle(3);
    check("left_with_right", pulse_cnt[CH_LEFT] - base, 1);
    check("right_suppressed", pulse_cnt[CH_RIGHT] - seen, 0);

    // Drop pressed while disabled, held across enable rising, then re-pressed.
    base = pulse_cnt[CH_DROP];
    en = 1'b0;
    keys[CH_DROP] = 1'b1;
    run_ticks(3);
    en = 1'b1;
    run_ticks(3);
    idle(2);
    check("drop_while_disabled", pulse_cnt[CH_DROP] - base, 0);
    keys[CH_DROP] = 1'b0;
    idle(2);
    keys[CH_DROP] = 1'b1;
    idle(2);
    keys[CH_DROP] = 1'b0;
    idle(2);
    check("drop_repress", pulse_cnt[CH_DROP] - base, 1);

    // Reset asserted mid-cycle while a REPEAT pulse is on the output.
    keys[CH_LEFT] = 1'b1;
    seen = 0;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick = (i % 3 == 0);
      step();
      if (last_exp[CH_LEFT]) begin
        seen++;
        if (seen == 3) found = 1;
      end
    end
    tick = 1'b0;
    check("repeat_reached", int'(found), 1);
    @(posedge clk);
    #2;
    check("left_before_reset", int'(kif.cmd_left), int'(found));
    rst = 1'b1;
    rst_drv = 1'b1;
    #1;
    check("async_reset_drop", int'(dut_cmds()), 0);
    keys = '0;
    idle(3);
    rst_drv = 1'b0;
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 5; c++)
        if ($urandom_range(0, 59) == 0) keys[c] = ~keys[c];
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) en = ~en;
      rst_drv = ($urandom_range(0, 1999) == 0);
      step();
    end

    keys = '0;
    en = 1'b1;
    rst_drv = 1'b0;
    idle(3);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
